// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS decode constants.
// Holds opcode and funct encodings plus the bit positions of every
// instruction field, so all decoders slice the word the same way.
package mips_pkg;

    // Instruction field bit positions
    localparam int unsigned OPCODE_HI = 31;
    localparam int unsigned OPCODE_LO = 26;
    localparam int unsigned RS_HI     = 25;
    localparam int unsigned RS_LO     = 21;
    localparam int unsigned RT_HI     = 20;
    localparam int unsigned RT_LO     = 16;
    localparam int unsigned RD_HI     = 15;
    localparam int unsigned RD_LO     = 11;
    localparam int unsigned SHAMT_HI  = 10;
    localparam int unsigned SHAMT_LO  = 6;
    localparam int unsigned FUNCT_HI  = 5;
    localparam int unsigned FUNCT_LO  = 0;
    localparam int unsigned IMME_HI   = 15;
    localparam int unsigned IMME_LO   = 0;
    localparam int unsigned JTGT_HI   = 25;
    localparam int unsigned JTGT_LO   = 0;

    // Opcodes
    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LB     = 6'h20;
    localparam logic [5:0] OP_LH     = 6'h21;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_LBU    = 6'h24;
    localparam logic [5:0] OP_LHU    = 6'h25;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SH     = 6'h29;
    localparam logic [5:0] OP_SW     = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

endpackage

// File: rtl/op_classify.sv
// op_classify: combinational opcode/funct classifier.
// Ports:
//   opcode   in  6  instruction opcode
//   funct    in  6  R-type funct field
//   ext_sign out 1  1 = immediate is sign-extended, 0 = zero-extended
//   illegal  out 1  opcode/funct outside the supported set
//                   (present only with ILLEGAL_OP_TRAP_EN defined)
module op_classify
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
`ifdef ILLEGAL_OP_TRAP_EN
    output logic       illegal,
`endif
    output logic       ext_sign
);

    always_comb begin
        ext_sign = 1'b0;
        unique case (opcode)
            OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ,
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
            OP_SB, OP_SH, OP_SW: ext_sign = 1'b1;
            default:             ext_sign = 1'b0;
        endcase
    end

`ifdef ILLEGAL_OP_TRAP_EN
    logic funct_ok;

    always_comb begin
        funct_ok = 1'b0;
        unique case (funct)
            FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
            FN_JR, FN_JALR, FN_MFHI, FN_MFLO,
            FN_MULT, FN_MULTU, FN_DIV, FN_DIVU,
            FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
            FN_AND, FN_OR, FN_XOR, FN_NOR,
            FN_SLT, FN_SLTU: funct_ok = 1'b1;
            default:         funct_ok = 1'b0;
        endcase
    end

    always_comb begin
        illegal = 1'b1;
        unique case (opcode)
            OP_RTYPE:                         illegal = ~funct_ok;
            OP_J, OP_JAL,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: illegal = 1'b0;
            default:                          illegal = ~ext_sign;
        endcase
    end
`else
    // funct only matters for the illegal-op check
    logic unused_funct;
    assign unused_funct = ^funct;
`endif

endmodule

// File: rtl/if_id_decode.sv
// if_id_decode: IF/ID pipeline register with instruction field decode.
// Latches the fetched instruction and PC under a valid/ready handshake with
// stall and flush, and presents the split fields plus a registered
// sign-extend select for the immediate extender.
// Optional macro: ILLEGAL_OP_TRAP_EN adds id_illegal.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   if_valid/if_instr/if_pc  fetch side instruction, PC
//   if_ready                 stage can accept an instruction this cycle
//   id_stall, flush          downstream stall, redirect kill
//   id_valid, id_pc          held instruction valid flag and its PC
//   id_opcode..id_jtarget    decoded fields of the held instruction
//   id_ext_sign              1 = sign-extend immediate
//   id_illegal               unsupported opcode/funct (macro only)
module if_id_decode
    import mips_pkg::*;
#(
    parameter int unsigned PC_W       = 32,
    parameter bit          FLUSH_ZERO = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [PC_W-1:0] if_pc,
    output logic            if_ready,
    input  logic            id_stall,
    input  logic            flush,
`ifdef ILLEGAL_OP_TRAP_EN
    output logic            id_illegal,
`endif
    output logic            id_valid,
    output logic [PC_W-1:0] id_pc,
    output logic [5:0]      id_opcode,
    output logic [4:0]      id_rs,
    output logic [4:0]      id_rt,
    output logic [4:0]      id_rd,
    output logic [4:0]      id_shamt,
    output logic [5:0]      id_funct,
    output logic [15:0]     id_imme,
    output logic            id_ext_sign,
    output logic [25:0]     id_jtarget
);

    logic            valid_q, valid_d;
    logic [31:0]     instr_q, instr_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            ext_sign_q, ext_sign_d;
    logic            ext_sign_in;
    logic            load;

`ifdef ILLEGAL_OP_TRAP_EN
    logic illegal_q, illegal_d;
    logic illegal_in;
`endif

    // Classify the incoming word so ext_sign is a flop output downstream
    op_classify u_op_classify (
        .opcode   (if_instr[OPCODE_HI:OPCODE_LO]),
        .funct    (if_instr[FUNCT_HI:FUNCT_LO]),
`ifdef ILLEGAL_OP_TRAP_EN
        .illegal  (illegal_in),
`endif
        .ext_sign (ext_sign_in)
    );

    // An empty stage never stalls, so a bubble is always overwritten
    assign if_ready = ~valid_q | ~id_stall;
    assign load     = if_valid & if_ready & ~flush;

    always_comb begin
        valid_d    = valid_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        ext_sign_d = ext_sign_q;
`ifdef ILLEGAL_OP_TRAP_EN
        illegal_d  = illegal_q;
`endif
        if (flush) begin
            valid_d = 1'b0;
            if (FLUSH_ZERO) begin
                instr_d    = '0;
                pc_d       = '0;
                ext_sign_d = 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
                illegal_d  = 1'b0;
`endif
            end
        end else if (load) begin
            valid_d    = 1'b1;
            instr_d    = if_instr;
            pc_d       = if_pc;
            ext_sign_d = ext_sign_in;
`ifdef ILLEGAL_OP_TRAP_EN
            illegal_d  = illegal_in;
`endif
        end else if (valid_q && !id_stall) begin
            // Consumed downstream; fields hold
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            instr_q    <= '0;
            pc_q       <= '0;
            ext_sign_q <= 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
            illegal_q  <= 1'b0;
`endif
        end else begin
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            ext_sign_q <= ext_sign_d;
`ifdef ILLEGAL_OP_TRAP_EN
            illegal_q  <= illegal_d;
`endif
        end
    end

    assign id_valid    = valid_q;
    assign id_pc       = pc_q;
    assign id_opcode   = instr_q[OPCODE_HI:OPCODE_LO];
    assign id_rs       = instr_q[RS_HI:RS_LO];
    assign id_rt       = instr_q[RT_HI:RT_LO];
    assign id_rd       = instr_q[RD_HI:RD_LO];
    assign id_shamt    = instr_q[SHAMT_HI:SHAMT_LO];
    assign id_funct    = instr_q[FUNCT_HI:FUNCT_LO];
    assign id_imme     = instr_q[IMME_HI:IMME_LO];
    assign id_jtarget  = instr_q[JTGT_HI:JTGT_LO];
    assign id_ext_sign = ext_sign_q;
`ifdef ILLEGAL_OP_TRAP_EN
    assign id_illegal  = illegal_q & valid_q;
`endif

endmodule

// File: tb/tb_if_id_decode.sv
module tb_if_id_decode;

    localparam int unsigned PC_W = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            if_valid;
    logic [31:0]     if_instr;
    logic [PC_W-1:0] if_pc;
    logic            if_ready;
    logic            id_stall;
    logic            flush;
    logic            id_valid;
    logic [PC_W-1:0] id_pc;
    logic [5:0]      id_opcode;
    logic [4:0]      id_rs, id_rt, id_rd, id_shamt;
    logic [5:0]      id_funct;
    logic [15:0]     id_imme;
    logic            id_ext_sign;
    logic [25:0]     id_jtarget;
`ifdef ILLEGAL_OP_TRAP_EN
    logic            id_illegal;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state: what the stage is holding
    bit          m_valid;
    bit [31:0]   m_instr;
    bit [31:0]   m_pc;
    bit          m_sign;
    bit          m_illegal;

    always #5 clk = ~clk;

    if_id_decode #(.PC_W(PC_W), .FLUSH_ZERO(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_ready    (if_ready),
        .id_stall    (id_stall),
        .flush       (flush),
`ifdef ILLEGAL_OP_TRAP_EN
        .id_illegal  (id_illegal),
`endif
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_opcode   (id_opcode),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_rd       (id_rd),
        .id_shamt    (id_shamt),
        .id_funct    (id_funct),
        .id_imme     (id_imme),
        .id_ext_sign (id_ext_sign),
        .id_jtarget  (id_jtarget)
    );

    function automatic bit sign_op(bit [5:0] op);
        bit [5:0] lst [17] = '{6'h01, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0A,
                               6'h0B, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29,
                               6'h2B};
        foreach (lst[i]) if (lst[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit illegal_of(bit [31:0] ins);
        bit [5:0] zlst [7] = '{6'h00, 6'h02, 6'h03, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
        bit [5:0] flst [18] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
                                6'h10, 6'h12, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h2A, 6'h2B,
                                6'h10, 6'h10};
        bit [5:0] op = ins[31:26];
        bit [5:0] fn = ins[5:0];
        bit known = sign_op(op);
        foreach (zlst[i]) if (zlst[i] == op) known = 1'b1;
        if (!known) return 1'b1;
        if (op != 6'h00) return 1'b0;
        if (fn >= 6'h20 && fn <= 6'h27) return 1'b0;
        foreach (flst[i]) if (flst[i] == fn) return 1'b0;
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, ":valid"}, {31'd0, id_valid}, {31'd0, m_valid});
        chk({tag, ":pc"}, id_pc, m_pc);
        chk({tag, ":opcode"}, {26'd0, id_opcode}, {26'd0, m_instr[31:26]});
        chk({tag, ":rs"}, {27'd0, id_rs}, {27'd0, m_instr[25:21]});
        chk({tag, ":rt"}, {27'd0, id_rt}, {27'd0, m_instr[20:16]});
        chk({tag, ":rd"}, {27'd0, id_rd}, {27'd0, m_instr[15:11]});
        chk({tag, ":shamt"}, {27'd0, id_shamt}, {27'd0, m_instr[10:6]});
        chk({tag, ":funct"}, {26'd0, id_funct}, {26'd0, m_instr[5:0]});
        chk({tag, ":imme"}, {16'd0, id_imme}, {16'd0, m_instr[15:0]});
        chk({tag, ":jtarget"}, {6'd0, id_jtarget}, {6'd0, m_instr[25:0]});
        chk({tag, ":ext_sign"}, {31'd0, id_ext_sign}, {31'd0, m_sign});
`ifdef ILLEGAL_OP_TRAP_EN
        chk({tag, ":illegal"}, {31'd0, id_illegal}, {31'd0, m_illegal & m_valid});
`endif
    endtask

    // One clock of stimulus: drive, check ready, clock, advance model, check outputs
    task automatic step(input string tag, input bit v, input bit [31:0] ins,
                        input bit [31:0] pc, input bit stall, input bit fl);
        bit rdy;
        if_valid = v; if_instr = ins; if_pc = pc; id_stall = stall; flush = fl;
        #1;
        rdy = !m_valid || !stall;
        chk({tag, ":if_ready"}, {31'd0, if_ready}, {31'd0, rdy});
        @(posedge clk);
        #1;
        if (fl) begin
            m_valid = 0; m_instr = 0; m_pc = 0; m_sign = 0; m_illegal = 0;
        end else if (v && rdy) begin
            m_valid = 1; m_instr = ins; m_pc = pc;
            m_sign = sign_op(ins[31:26]); m_illegal = illegal_of(ins);
        end else if (m_valid && !stall) begin
            m_valid = 0;
        end
        chk_outputs(tag);
    endtask

    initial begin
        bit [31:0] ins;
        rst_n = 1'b0; if_valid = 0; if_instr = 0; if_pc = 0; id_stall = 0; flush = 0;
        m_valid = 0; m_instr = 0; m_pc = 0; m_sign = 0; m_illegal = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_outputs("reset");
        rst_n = 1'b1;
        #1;
        chk("reset:if_ready", {31'd0, if_ready}, 32'd1);

        // Load addi and fixed-value spot checks
        step("addi", 1, 32'h2008FFFF, 32'h00400000, 0, 0);
        chk("addi:opcode_lit", {26'd0, id_opcode}, 32'h08);
        chk("addi:rt_lit", {27'd0, id_rt}, 32'd8);
        chk("addi:sign_lit", {31'd0, id_ext_sign}, 32'd1);
        step("ori", 1, 32'h3408FFFF, 32'h00400004, 0, 0);
        chk("ori:sign_lit", {31'd0, id_ext_sign}, 32'd0);
        chk("ori:imme_lit", {16'd0, id_imme}, 32'h0000FFFF);
        step("lw", 1, 32'h8D09FFFC, 32'h00400008, 0, 0);
        chk("lw:rs_lit", {27'd0, id_rs}, 32'd8);
        chk("lw:rt_lit", {27'd0, id_rt}, 32'd9);

        // Stall holds lw while ori waits at fetch
        for (int i = 0; i < 3; i++) begin
            step("stall", 1, 32'h3408FFFF, 32'h0040000C, 1, 0);
            chk("stall:ready_lit", {31'd0, if_ready}, 32'd0);
            chk("stall:instr_lit", {id_opcode, id_rs, id_rt, id_imme}, 32'h8D09FFFC);
        end
        step("unstall", 1, 32'h3408FFFF, 32'h0040000C, 0, 0);
        chk("unstall:ori_lit", {id_opcode, id_rs, id_rt, id_imme}, 32'h3408FFFF);

        // Flush beats a concurrent load
        step("flush", 1, 32'h2008FFFF, 32'h00400010, 0, 1);
        chk("flush:valid_lit", {31'd0, id_valid}, 32'd0);
        chk("flush:imme_lit", {16'd0, id_imme}, 32'd0);

        // Bubble with stall is overwritten; consume without load
        step("bubble", 1, 32'h8D09FFFC, 32'h00400014, 1, 0);
        step("consume", 0, 32'h0, 32'h0, 0, 0);

        // Asynchronous reset between edges during a stall
        step("pre_rst", 1, 32'h2008FFFF, 32'h00400018, 1, 0);
        step("pre_rst2", 1, 32'h3408FFFF, 32'h0040001C, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        m_valid = 0; m_instr = 0; m_pc = 0; m_sign = 0; m_illegal = 0;
        chk_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("async_rst:if_ready", {31'd0, if_ready}, 32'd1);

`ifdef ILLEGAL_OP_TRAP_EN
        step("ill_op", 1, 32'hFC000000, 32'h00400020, 0, 0);
        chk("ill_op:lit", {31'd0, id_illegal}, 32'd1);
        step("ill_fn", 1, 32'h0000003F, 32'h00400024, 0, 0);
        chk("ill_fn:lit", {31'd0, id_illegal}, 32'd1);
        step("addu", 1, 32'h01095021, 32'h00400028, 0, 0);
        chk("addu:lit", {31'd0, id_illegal}, 32'd0);
        chk("addu:rd_lit", {27'd0, id_rd}, 32'd10);
        step("ill_drain", 0, 32'h0, 32'h0, 0, 0);
`endif

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            ins = $urandom;
            if ($urandom_range(1, 0) == 1) begin
                // Bias toward the defined opcodes
                ins[31:26] = 6'($urandom_range(15, 0));
                if ($urandom_range(2, 0) == 0) ins[31:26] = 6'($urandom_range(43, 32));
            end
            step("rand", $urandom_range(9, 0) < 7, ins, $urandom,
                 $urandom_range(9, 0) < 3, $urandom_range(9, 0) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
